// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - shared helpers and constants for the AXI-Stream width converters
package axis_width_pkg;

    localparam int STAT_WIDTH = 32;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a slice index; never narrower than one bit so DIVISOR=1 still has a register.
    function automatic int idx_width(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_width_downsizer_stats.sv
// rtl/axis_width_downsizer_stats.sv - narrow-side packet and beat counters for the downsizer
module axis_width_downsizer_stats
    import axis_width_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  m_axis_tlast,
    output logic [STAT_WIDTH-1:0] stat_pkt_count,
    output logic [STAT_WIDTH-1:0] stat_beat_count
);

    logic beat_fire;

    assign beat_fire = m_axis_tvalid && m_axis_tready;

    // Count every narrow handshake, and those closing a packet; both wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkt_count  <= '0;
            stat_beat_count <= '0;
        end else if (beat_fire) begin
            stat_beat_count <= stat_beat_count + 1'b1;
            if (m_axis_tlast) begin
                stat_pkt_count <= stat_pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_width_downsizer.sv
// rtl/axis_width_downsizer.sv - registered AXI-Stream wide-to-narrow converter; WIDTH_DOWNSIZER_STATS_EN adds counters
module axis_width_downsizer
    import axis_width_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 64,
    parameter int DIVISOR      = 4,
    parameter int USER_WIDTH   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [OUTPUT_WIDTH*DIVISOR-1:0]  s_axis_tdata,
    input  logic [OUTPUT_WIDTH*DIVISOR/8-1:0] s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic [OUTPUT_WIDTH-1:0]          m_axis_tdata,
    output logic [OUTPUT_WIDTH/8-1:0]        m_axis_tkeep,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready
`ifdef WIDTH_DOWNSIZER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]            stat_pkt_count,
    output logic [STAT_WIDTH-1:0]            stat_beat_count
`endif
);

    localparam int IN_W  = OUTPUT_WIDTH * DIVISOR;
    localparam int IN_KW = IN_W / 8;
    localparam int KW    = OUTPUT_WIDTH / 8;
    localparam int IW    = idx_width(DIVISOR);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIVISOR - 1);

    logic                    buf_valid;
    logic [IN_W-1:0]         buf_data;
    logic [IN_KW-1:0]        buf_keep;
    logic [USER_WIDTH-1:0]   buf_user;
    logic                    buf_last;
    logic [IW-1:0]           idx;

    logic [OUTPUT_WIDTH-1:0] slice_data;
    logic [KW-1:0]           slice_keep;
    logic                    next_empty;
    logic                    last_slice;
    logic                    tlast_int;
    logic                    final_slice;
    logic                    accept;
    logic                    m_fire;

    // Select the current slice and look ahead at the first keep bit of the following slice.
    always_comb begin
        slice_data = '0;
        slice_keep = '0;
        next_empty = 1'b0;
        for (int i = 0; i < DIVISOR; i++) begin
            if (idx == IW'(i)) begin
                slice_data = buf_data[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                slice_keep = buf_keep[i*KW +: KW];
            end
        end
        for (int i = 0; i < DIVISOR - 1; i++) begin
            if (idx == IW'(i)) begin
                next_empty = (buf_keep[(i+1)*KW] == 1'b0);
            end
        end
    end

    assign last_slice  = (idx == LAST_IDX);
    assign tlast_int   = buf_last && (last_slice || next_empty);
    assign final_slice = last_slice || tlast_int;

    // A new wide beat may load in the same cycle the held beat's final slice leaves.
    assign s_axis_tready = !reset && (!buf_valid || (m_axis_tready && final_slice));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = buf_valid && m_axis_tready;

    assign m_axis_tvalid = buf_valid;
    assign m_axis_tdata  = slice_data;
    assign m_axis_tkeep  = slice_keep;
    assign m_axis_tuser  = buf_user;
    assign m_axis_tlast  = tlast_int;

    // Holding register: load on accept, otherwise step through slices and drain on the final one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_keep  <= '0;
            buf_user  <= '0;
            buf_last  <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_data  <= s_axis_tdata;
            buf_keep  <= s_axis_tkeep;
            buf_user  <= s_axis_tuser;
            buf_last  <= s_axis_tlast;
            idx       <= '0;
        end else if (m_fire) begin
            if (final_slice) begin
                buf_valid <= 1'b0;
                idx       <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef WIDTH_DOWNSIZER_STATS_EN
    axis_width_downsizer_stats u_stats (
        .clk             (clk),
        .reset           (reset),
        .m_axis_tvalid   (buf_valid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (tlast_int),
        .stat_pkt_count  (stat_pkt_count),
        .stat_beat_count (stat_beat_count)
    );
`endif

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb/tb_axis_width_downsizer.sv - directed self-checking bench for axis_width_downsizer (OUTPUT_WIDTH=64, DIVISOR=4)
module tb_axis_width_downsizer;

    localparam int OW = 64;
    localparam int DV = 4;
    localparam int UW = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [OW*DV-1:0]  s_data;
    logic [OW*DV/8-1:0] s_keep;
    logic [UW-1:0]     s_user;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [OW-1:0]     m_data;
    logic [OW/8-1:0]   m_keep;
    logic [UW-1:0]     m_user;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
`ifdef WIDTH_DOWNSIZER_STATS_EN
    logic [31:0]       stat_pkt;
    logic [31:0]       stat_beat;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        logic [OW-1:0]   data;
        logic [OW/8-1:0] keep;
        logic [UW-1:0]   user;
        logic            last;
        int              c;
    } beat_t;

    beat_t mq[$];
    int    aq[$];

    axis_width_downsizer #(
        .OUTPUT_WIDTH (OW),
        .DIVISOR      (DV),
        .USER_WIDTH   (UW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tuser  (s_user),
        .s_axis_tlast  (s_last),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready)
`ifdef WIDTH_DOWNSIZER_STATS_EN
        ,
        .stat_pkt_count  (stat_pkt),
        .stat_beat_count (stat_beat)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) mq.push_back('{m_data, m_keep, m_user, m_last, cyc});
        if (!reset && s_valid && s_ready) aq.push_back(cyc);
    end

    function automatic logic [63:0] w(input int p, input int i);
        return {32'hC0DE0000 + 32'(p), 32'(i)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [31:0] keep, input logic last, input logic user);
        int n;
        s_data  = {w(p, 3), w(p, 2), w(p, 1), w(p, 0)};
        s_keep  = keep;
        s_last  = last;
        s_user  = user;
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            total++;
            $display("FAIL send_timeout pkt=%0d s_axis_tready never rose within 50 cycles", p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
    endtask

    task automatic clear();
        mq.delete();
        aq.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_user = '0; s_last = 1'b0; m_ready = 1'b0;
        tick(2);
        total++; if (m_valid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", m_valid); else passed++;
        total++; if (m_last !== 1'b0) $display("FAIL rst_tlast got %b want 0", m_last); else passed++;
        total++; if (m_data !== 64'h0) $display("FAIL rst_tdata got %h want 0", m_data); else passed++;
        total++; if (m_keep !== 8'h0) $display("FAIL rst_tkeep got %h want 0", m_keep); else passed++;
        total++; if (m_user !== 1'b0) $display("FAIL rst_tuser got %b want 0", m_user); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL rst_sready got %b want 0", s_ready); else passed++;
        reset = 1'b0;
        tick(1);
        total++; if (s_ready !== 1'b1) $display("FAIL post_rst_sready got %b want 1", s_ready); else passed++;
    endtask

    task automatic test_single_beat();
        clear();
        m_ready = 1'b1;
        send(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        for (int k = 0; k < 4; k++) begin
            total++; if (s_ready !== (k == 3)) $display("FAIL single_sready k=%0d got %b want %b", k, s_ready, (k == 3)); else passed++;
            tick(1);
        end
        tick(3);
        total++; if (mq.size() != 4) $display("FAIL single_count got %0d want 4", mq.size()); else passed++;
        for (int i = 0; i < 4 && i < mq.size(); i++) begin
            total++; if (mq[i].data !== w(1, i)) $display("FAIL single_data%0d got %h want %h", i, mq[i].data, w(1, i)); else passed++;
            total++; if (mq[i].keep !== 8'hFF) $display("FAIL single_keep%0d got %h want ff", i, mq[i].keep); else passed++;
            total++; if (mq[i].last !== (i == 3)) $display("FAIL single_last%0d got %b want %b", i, mq[i].last, (i == 3)); else passed++;
        end
        if (mq.size() > 0 && aq.size() > 0) begin
            total++; if (mq[0].c != aq[0] + 1) $display("FAIL single_latency got %0d want %0d", mq[0].c - aq[0], 1); else passed++;
        end
    endtask

    task automatic test_short_tail();
        logic [63:0] ed [6];
        logic [7:0]  ek [6];
        ed = '{w(2, 0), w(2, 1), w(2, 2), w(2, 3), w(3, 0), w(3, 1)};
        ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        clear();
        m_ready = 1'b1;
        send(2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(3, 32'h0000_0FFF, 1'b1, 1'b0);
        idle();
        tick(8);
        total++; if (mq.size() != 6) $display("FAIL tail_count got %0d want 6", mq.size()); else passed++;
        for (int i = 0; i < 6 && i < mq.size(); i++) begin
            total++; if (mq[i].data !== ed[i]) $display("FAIL tail_data%0d got %h want %h", i, mq[i].data, ed[i]); else passed++;
            total++; if (mq[i].keep !== ek[i]) $display("FAIL tail_keep%0d got %h want %h", i, mq[i].keep, ek[i]); else passed++;
            total++; if (mq[i].last !== (i == 5)) $display("FAIL tail_last%0d got %b want %b", i, mq[i].last, (i == 5)); else passed++;
        end
        clear();
        send(4, 32'h0000_0000, 1'b1, 1'b0);
        idle();
        tick(4);
        total++; if (mq.size() != 1) $display("FAIL zerokeep_count got %0d want 1", mq.size()); else passed++;
        if (mq.size() > 0) begin
            total++; if (mq[0].keep !== 8'h00) $display("FAIL zerokeep_keep got %h want 00", mq[0].keep); else passed++;
            total++; if (mq[0].last !== 1'b1) $display("FAIL zerokeep_last got %b want 1", mq[0].last); else passed++;
            total++; if (mq[0].data !== w(4, 0)) $display("FAIL zerokeep_data got %h want %h", mq[0].data, w(4, 0)); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        clear();
        m_ready = 1'b1;
        send(5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(6, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(7, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        tick(8);
        total++; if (mq.size() != 12) $display("FAIL b2b_count got %0d want 12", mq.size()); else passed++;
        total++; if (aq.size() != 3) $display("FAIL b2b_accepts got %0d want 3", aq.size()); else passed++;
        for (int i = 0; i < 12 && i < mq.size() && aq.size() > 0; i++) begin
            total++; if (mq[i].data !== w(5 + i / 4, i % 4)) $display("FAIL b2b_data%0d got %h want %h", i, mq[i].data, w(5 + i / 4, i % 4)); else passed++;
            total++; if (mq[i].c != aq[0] + 1 + i) $display("FAIL b2b_cycle%0d got %0d want %0d", i, mq[i].c, aq[0] + 1 + i); else passed++;
            total++; if (mq[i].last !== (i == 11)) $display("FAIL b2b_last%0d got %b want %b", i, mq[i].last, (i == 11)); else passed++;
        end
    endtask

    task automatic test_backpressure();
        clear();
        m_ready = 1'b0;
        fork
            begin
                send(8, 32'hFFFF_FFFF, 1'b1, 1'b1);
                idle();
            end
            begin
                logic [63:0] pd;
                logic [7:0]  pk;
                logic        pu, pl, pv, stall;
                stall = 1'b0;
                pd = '0; pk = '0; pu = 1'b0; pl = 1'b0; pv = 1'b0;
                for (int k = 0; k < 14; k++) begin
                    m_ready = (k % 2 == 0);
                    @(negedge clk);
                    if (stall) begin
                        total++;
                        if ({m_valid, m_data, m_keep, m_user, m_last} !== {pv, pd, pk, pu, pl})
                            $display("FAIL bp_stable k=%0d got %b/%h/%h/%b/%b want %b/%h/%h/%b/%b", k, m_valid, m_data, m_keep, m_user, m_last, pv, pd, pk, pu, pl);
                        else passed++;
                    end
                    stall = m_valid && !m_ready;
                    pv = m_valid; pd = m_data; pk = m_keep; pu = m_user; pl = m_last;
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_ready = 1'b1;
        tick(2);
        total++; if (mq.size() != 4) $display("FAIL bp_count got %0d want 4", mq.size()); else passed++;
        for (int i = 0; i < 4 && i < mq.size(); i++) begin
            total++; if (mq[i].data !== w(8, i)) $display("FAIL bp_data%0d got %h want %h", i, mq[i].data, w(8, i)); else passed++;
            total++; if (mq[i].user !== 1'b1) $display("FAIL bp_user%0d got %b want 1", i, mq[i].user); else passed++;
            total++; if (mq[i].last !== (i == 3)) $display("FAIL bp_last%0d got %b want %b", i, mq[i].last, (i == 3)); else passed++;
        end
    endtask

    task automatic test_reset_mid_packet();
        clear();
        m_ready = 1'b1;
        send(9, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        tick(2);
        total++; if (mq.size() != 2) $display("FAIL rstmid_pre_count got %0d want 2", mq.size()); else passed++;
        reset = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) $display("FAIL rstmid_tvalid got %b want 0", m_valid); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL rstmid_sready got %b want 0", s_ready); else passed++;
        tick(1);
        reset = 1'b0;
        clear();
        send(10, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle();
        tick(5);
        total++; if (mq.size() != 4) $display("FAIL rstmid_post_count got %0d want 4", mq.size()); else passed++;
        if (mq.size() > 0) begin
            total++; if (mq[0].data !== w(10, 0)) $display("FAIL rstmid_first_data got %h want %h", mq[0].data, w(10, 0)); else passed++;
        end
        if (mq.size() == 4) begin
            total++; if (mq[3].last !== 1'b1) $display("FAIL rstmid_last got %b want 1", mq[3].last); else passed++;
        end
    endtask

`ifdef WIDTH_DOWNSIZER_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_ready = 1'b1;
        tick(1);
        total++; if (stat_beat !== 32'd0) $display("FAIL stats_rst_beat got %0d want 0", stat_beat); else passed++;
        send(11, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(12, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(13, 32'h0000_0FFF, 1'b1, 1'b0);
        send(14, 32'h0000_00FF, 1'b1, 1'b0);
        idle();
        tick(8);
        total++; if (stat_pkt !== 32'd3) $display("FAIL stats_pkt got %0d want 3", stat_pkt); else passed++;
        total++; if (stat_beat !== 32'd11) $display("FAIL stats_beat got %0d want 11", stat_beat); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_short_tail();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
`ifdef WIDTH_DOWNSIZER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_width_downsizer.md
# axis_width_downsizer

Parametrised AXI4-Stream downsizer for the 10G input path. It registers one wide beat and emits it as up to DIVISOR narrow beats. A packet's final wide beat is cut short at the first empty slice. The block sits between the wide MAC-side datapath and the narrower input-arbiter datapath. Unlike the previous generation, it has a registered holding stage (no combinational s→m path), supports a parametrised user width, sustains full throughput across wide-beat boundaries, and can optionally compile in statistics counters.

## Interface
Parameters:
- OUTPUT_WIDTH, 64: narrow data width in bits; multiple of 8.
- DIVISOR, 4: wide/narrow ratio, ≥1; the wide width is OUTPUT_WIDTH*DIVISOR.
- USER_WIDTH, 1: tuser width on both sides.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  single clock.
  - reset  in  1  asynchronous, active-high.
- Slave (wide) side:
  - s_axis_tdata  in  OUTPUT_WIDTH*DIVISOR  wide data; slice 0 is the LSBs.
  - s_axis_tkeep  in  OUTPUT_WIDTH*DIVISOR/8  byte enables.
  - s_axis_tuser  in  USER_WIDTH  sideband.
  - s_axis_tlast  in  1  end of packet.
  - s_axis_tvalid  in  1.
  - s_axis_tready  out  1.
- Master (narrow) side:
  - m_axis_tdata  out  OUTPUT_WIDTH.
  - m_axis_tkeep  out  OUTPUT_WIDTH/8.
  - m_axis_tuser  out  USER_WIDTH  copied from the held wide beat onto every slice.
  - m_axis_tlast  out  1.
  - m_axis_tvalid  out  1.
  - m_axis_tready  in  1.
- Statistics (only with WIDTH_DOWNSIZER_STATS_EN):
  - stat_pkt_count  out  32  packets emitted.
  - stat_beat_count  out  32  narrow beats emitted.

## Operation
- Holding register state:
  - buf_valid, buf_data, buf_keep, buf_user, buf_last.
  - Slice index idx, width max(1, clog2(DIVISOR)).
- Outputs from the holding register:
  - m_axis_tvalid = buf_valid.
  - m_axis_tdata / m_axis_tkeep = slice idx of buf_data / buf_keep.
- Early end: next_empty = (idx < DIVISOR-1) && buf_keep[(idx+1)*OUTPUT_WIDTH/8] == 0.
- m_axis_tlast = buf_last && (idx == DIVISOR-1 || next_empty).
- final_slice = (idx == DIVISOR-1) || m_axis_tlast.
- s_axis_tready = !reset && (!buf_valid || (m_axis_tready && final_slice)).
- Accept, i.e. s_axis_tvalid && s_axis_tready: load all buf fields, idx←0, buf_valid←1. Accept takes priority over the drain case below.
- Narrow handshake on a non-final slice: idx←idx+1.
- Narrow handshake on the final slice with no simultaneous accept: buf_valid←0, idx←0.
- Slice skipping: only a tlast beat can end early. Non-last wide beats always emit all DIVISOR slices, whatever their tkeep.
- Zero keep: a tlast beat with slice 0 keep of zero still emits one narrow beat, with keep 0 and tlast=1.
- DIVISOR=1: the block degenerates to a one-entry register slice.

## Timing
- Reset values: buf_valid=0, idx=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tuser=0, s_axis_tready=0 while reset is asserted and 1 from the first edge after release. Counters reset to 0.
- Latency: first narrow beat is valid the cycle after the wide beat is accepted.
- Throughput: one narrow beat per cycle when m_axis_tready=1. A new wide beat loads in the same cycle its predecessor's final slice handshakes, so there is no bubble.
- AXI stability: while m_axis_tvalid && !m_axis_tready, all m_axis outputs are held stable.
- Reset mid-packet: the held beat is discarded immediately (asynchronous). The next accepted beat starts at slice 0.

## Configuration
- WIDTH_DOWNSIZER_STATS_EN defined:
  - stat_beat_count increments on every narrow handshake.
  - stat_pkt_count increments on every narrow handshake with m_axis_tlast=1.
  - Both wrap at 2^32.
- Macro undefined: both counters and both ports are absent, and datapath behaviour is identical.

## Structure
- Shared package axis_width_pkg holds:
  - the clog2 function;
  - the idx-width constant helper: max(1, clog2(N));
  - the STAT_WIDTH=32 constant.
- One sub-module: axis_width_downsizer_stats. It contains the two counters and is instantiated only under the macro.

## Test plan
All scenarios use OUTPUT_WIDTH=64 and DIVISOR=4.
- Single full beat: one wide beat with keep 0xFFFFFFFF, tlast=1, words D0..D3, and m_axis_tready=1 → four beats D0..D3 with keep 0xFF each; tlast only on D3; s_axis_tready low for 3 cycles.
- Short tail: two-beat packet, second beat keep 0x00000FFF → 4+2 narrow beats; last has keep 0x0F and tlast=1; slices 2 and 3 are not emitted.
- Throughput: three back-to-back full wide beats with the sink always ready → 12 narrow beats on 12 consecutive cycles, first one cycle after the first accept.
- Backpressure: m_axis_tready toggles 1,0,1,0 → no slice lost or duplicated; outputs stable in every not-ready cycle; tuser=1 on all slices of a tuser=1 beat.
- Reset mid-packet: reset asserted after 2 of 4 slices → m_axis_tvalid=0 immediately; the next packet begins with its own slice 0.
- Stats (macro defined): three packets of 4, 6 and 1 narrow beats → stat_pkt_count=3, stat_beat_count=11.
